// File: rtl/rx_session_ctrl.sv
// Receive-session sequencer: arms detectors, supervises each frame with a watchdog and keeps frame statistics.
// Optional statistics counters are built only when RX_SESSION_STATS_EN is defined; otherwise they read 0.
module rx_session_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned HOLDOFF_CYCLES = 8,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_enable,
  input  logic                 SD_flag,
  input  logic                 PD_flag,
  input  logic                 BD_flag,
  input  logic                 disassert_PD,
  input  logic                 data_tvalid,
  input  logic                 data_tready,
  input  logic                 data_tlast,
  output logic                 pd_enable,
  output logic                 bd_enable,
  output logic                 depkt_rst,
  output logic                 busy,
  output logic [2:0]           state_o,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic [CNT_WIDTH-1:0] drop_count,
  output logic [CNT_WIDTH-1:0] timeout_count
);

  // One timer serves as watchdog in SYNC/RECV and as the HOLDOFF counter.
  localparam int unsigned TMR_MAX = (TIMEOUT_CYCLES > HOLDOFF_CYCLES) ? TIMEOUT_CYCLES : HOLDOFF_CYCLES;
  localparam int unsigned TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEARCH  = 3'd1,
    ST_SYNC    = 3'd2,
    ST_RECV    = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             pd_en_q, pd_en_d;
  logic             bd_en_q, bd_en_d;
  logic             busy_q, busy_d;
  logic             rst_pulse_q, rst_pulse_d;
  logic             beat;
  logic             wdog_exp;

  assign beat     = data_tvalid & data_tready;
  assign wdog_exp = (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      ST_IDLE: begin
        if (SD_flag) state_d = ST_SEARCH;
      end
      ST_SEARCH: begin
        if (PD_flag)       state_d = ST_SYNC;
        else if (!SD_flag) state_d = ST_IDLE;
      end
      ST_SYNC: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (BD_flag)       state_d = ST_RECV;
        else if (!SD_flag) state_d = ST_IDLE;
        else if (wdog_exp) state_d = ST_HOLDOFF;
      end
      ST_RECV: begin
        tmr_d = beat ? '0 : tmr_q + TMR_W'(1);
        // Exit priority: good packet, SD drop, header abort, stall.
        if (beat && data_tlast)      state_d = ST_HOLDOFF;
        else if (!SD_flag)           state_d = ST_HOLDOFF;
        else if (disassert_PD)       state_d = ST_HOLDOFF;
        else if (!beat && wdog_exp)  state_d = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (tmr_q == TMR_W'(HOLDOFF_CYCLES - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) tmr_d = '0;

    pd_en_d     = (state_d == ST_SEARCH) || (state_d == ST_SYNC);
    bd_en_d     = (state_d == ST_SYNC);
    busy_d      = (state_d != ST_IDLE);
    rst_pulse_d = (state_d == ST_HOLDOFF) && (state_q != ST_HOLDOFF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      pd_en_q     <= 1'b0;
      bd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      rst_pulse_q <= 1'b0;
    end else if (clk_enable) begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      pd_en_q     <= pd_en_d;
      bd_en_q     <= bd_en_d;
      busy_q      <= busy_d;
      rst_pulse_q <= rst_pulse_d;
    end
  end

  assign pd_enable = pd_en_q;
  assign bd_enable = bd_en_q;
  assign busy      = busy_q;
  assign depkt_rst = rst_pulse_q;
  assign state_o   = state_q;

`ifdef RX_SESSION_STATS_EN
  logic                 enter_hold;
  logic                 pkt_inc, drop_inc, to_inc;
  logic [CNT_WIDTH-1:0] pkt_q, drop_q, to_q;

  // Classify the HOLDOFF entry by the same priority the FSM used.
  assign enter_hold = (state_d == ST_HOLDOFF) && (state_q != ST_HOLDOFF);
  assign pkt_inc    = enter_hold && (state_q == ST_RECV) && beat && data_tlast;
  assign drop_inc   = enter_hold && (state_q == ST_RECV) && !(beat && data_tlast)
                      && (!SD_flag || disassert_PD);
  assign to_inc     = enter_hold && !pkt_inc && !drop_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q  <= '0;
      drop_q <= '0;
      to_q   <= '0;
    end else if (clk_enable) begin
      if (pkt_inc && !(&pkt_q))   pkt_q  <= pkt_q + CNT_WIDTH'(1);
      if (drop_inc && !(&drop_q)) drop_q <= drop_q + CNT_WIDTH'(1);
      if (to_inc && !(&to_q))     to_q   <= to_q + CNT_WIDTH'(1);
    end
  end

  assign pkt_count     = pkt_q;
  assign drop_count    = drop_q;
  assign timeout_count = to_q;
`else
  assign pkt_count     = '0;
  assign drop_count    = '0;
  assign timeout_count = '0;
`endif

endmodule

// File: tb/tb_rx_session_ctrl.sv
// Randomized bench for rx_session_ctrl against a behavioural session model.
module tb_rx_session_ctrl;

  localparam int T  = 16;
  localparam int H  = 8;
  localparam int CW = 3;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef RX_SESSION_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_enable = 1'b0;
  logic SD_flag = 1'b0, PD_flag = 1'b0, BD_flag = 1'b0, disassert_PD = 1'b0;
  logic data_tvalid = 1'b0, data_tready = 1'b0, data_tlast = 1'b0;
  logic pd_enable, bd_enable, depkt_rst, busy;
  logic [2:0] state_o;
  logic [CW-1:0] pkt_count, drop_count, timeout_count;

  always #5 clk = ~clk;

  rx_session_ctrl #(
    .TIMEOUT_CYCLES(T),
    .HOLDOFF_CYCLES(H),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable),
    .SD_flag(SD_flag), .PD_flag(PD_flag), .BD_flag(BD_flag),
    .disassert_PD(disassert_PD),
    .data_tvalid(data_tvalid), .data_tready(data_tready), .data_tlast(data_tlast),
    .pd_enable(pd_enable), .bd_enable(bd_enable), .depkt_rst(depkt_rst),
    .busy(busy), .state_o(state_o),
    .pkt_count(pkt_count), .drop_count(drop_count), .timeout_count(timeout_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Session model: state name, cycles since last progress, holdoff cycles left, event tallies.
  int m_st, m_stall, m_hold, m_pkt, m_drop, m_to;
  bit m_rst;
  int stall_left = 0;
  bit en_mode = 1'b0;

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic model_reset();
    m_st = 0; m_stall = 0; m_hold = 0;
    m_pkt = 0; m_drop = 0; m_to = 0; m_rst = 1'b0;
  endtask

  task automatic model_step();
    int nx;
    bit beat, go_hold;
    nx = m_st;
    go_hold = 1'b0;
    beat = data_tvalid && data_tready;
    case (m_st)
      0: if (SD_flag) nx = 1;
      1: if (PD_flag) nx = 2; else if (!SD_flag) nx = 0;
      2: begin
        m_stall++;
        if (BD_flag) nx = 3;
        else if (!SD_flag) nx = 0;
        else if (m_stall >= T) begin go_hold = 1'b1; m_to++; end
      end
      3: begin
        m_stall = beat ? 0 : m_stall + 1;
        if (beat && data_tlast) begin go_hold = 1'b1; m_pkt++; end
        else if (!SD_flag || disassert_PD) begin go_hold = 1'b1; m_drop++; end
        else if (!beat && m_stall >= T) begin go_hold = 1'b1; m_to++; end
      end
      default: begin
        m_hold--;
        if (m_hold == 0) nx = 0;
      end
    endcase
    if (go_hold) begin nx = 4; m_hold = H; end
    if (nx != m_st && (nx == 2 || nx == 3)) m_stall = 0;
    m_rst = go_hold;
    m_st = nx;
  endtask

  task automatic compare_all();
    check_eq("state_o", 32'(state_o), 32'(m_st));
    check_eq("pd_enable", 32'(pd_enable), 32'(m_st == 1 || m_st == 2));
    check_eq("bd_enable", 32'(bd_enable), 32'(m_st == 2));
    check_eq("busy", 32'(busy), 32'(m_st != 0));
    check_eq("depkt_rst", 32'(depkt_rst), 32'(m_rst));
    check_eq("pkt_count", 32'(pkt_count), STATS ? 32'(sat(m_pkt)) : 32'd0);
    check_eq("drop_count", 32'(drop_count), STATS ? 32'(sat(m_drop)) : 32'd0);
    check_eq("timeout_count", 32'(timeout_count), STATS ? 32'(sat(m_to)) : 32'd0);
  endtask

  task automatic drive_random();
    clk_enable = en_mode ? ($urandom_range(0, 3) == 0) : 1'b1;
    SD_flag = (m_st == 0) ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) >= 3);
    PD_flag = $urandom_range(0, 99) < 20;
    BD_flag = $urandom_range(0, 99) < 12;
    if (m_st == 3 && stall_left == 0 && $urandom_range(0, 99) < 2)
      stall_left = $urandom_range(10, 25);
    data_tvalid = $urandom_range(0, 99) < 80;
    data_tready = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 99) < 75);
    data_tlast = $urandom_range(0, 99) < 5;
    disassert_PD = $urandom_range(0, 99) < 2;
    if (stall_left > 0 && clk_enable) stall_left--;
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      compare_all();
      if (m_st == 3 && $urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #1 model_reset();
        stall_left = 0;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
      end
      if (cyc % 500 == 0) en_mode = 1'($urandom_range(0, 1));
      drive_random();
      if (clk_enable) model_step();
    end
    @(negedge clk);
    compare_all();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_session_ctrl.md
# rx_session_ctrl

Receive-session sequencer for the PSK receive chain. It watches signal detect, preamble detect and barker detect, and observes the depacketizer's output stream. It enables each detector stage in turn, supervises each frame with a watchdog, and issues a one-cycle soft reset to the depacketizer and detectors when a frame completes, aborts or stalls. It sits between the detector front end and the depacketizer and also keeps frame statistics for the host.

## Interface
Parameters:
- TIMEOUT_CYCLES, 4096: enabled cycles without progress in SYNC/RECV before abort (≥2)
- HOLDOFF_CYCLES, 8: enabled cycles spent in HOLDOFF before re-arming (≥1)
- CNT_WIDTH, 16: width of statistics counters

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- clk_enable  in  1  symbol-rate enable; all state/counter updates occur only when high
- SD_flag  in  1  signal detect
- PD_flag  in  1  preamble detect
- BD_flag  in  1  barker detect
- disassert_PD  in  1  depacketizer end/abort indication
- data_tvalid, data_tready, data_tlast  in  1 each  depacketizer output stream, observed only
- pd_enable  out  1  arm preamble detector
- bd_enable  out  1  arm barker detector
- depkt_rst  out  1  one-cycle synchronous soft reset to depacketizer and detectors
- busy  out  1  high in any state except IDLE
- state_o  out  3  current state encoding
- pkt_count, drop_count, timeout_count  out  CNT_WIDTH each  saturating statistics

## Operation
- States: IDLE=0, SEARCH=1, SYNC=2, RECV=3, HOLDOFF=4; other codes return to IDLE.
- IDLE: SD_flag → SEARCH.
- SEARCH: pd_enable=1. PD_flag → SYNC. SD_flag low → IDLE.
- SYNC: pd_enable=1, bd_enable=1. BD_flag → RECV. SD_flag low → IDLE. Watchdog expiry → HOLDOFF with timeout_count+1 and depkt_rst.
- RECV: watchdog clears on every beat where data_tvalid&data_tready.
- RECV exits, highest priority first:
  - (a) data_tvalid&data_tready&data_tlast → HOLDOFF, pkt_count+1.
  - (b) SD_flag low → HOLDOFF, drop_count+1.
  - (c) disassert_PD without an accepted tlast → HOLDOFF, drop_count+1 (header abort).
  - (d) watchdog = TIMEOUT_CYCLES−1 → HOLDOFF, timeout_count+1.
- Every transition into HOLDOFF asserts depkt_rst for exactly one enabled cycle.
- HOLDOFF: counts HOLDOFF_CYCLES enabled cycles, then goes to IDLE. Flags are ignored during HOLDOFF.
- Watchdog clears on entry to SYNC and to RECV.
- Simultaneous events: a last beat and SD drop in the same cycle count as a good packet. Timeout and progress in the same cycle count as progress.
- Counters saturate at all-ones; they never wrap.

## Timing
- All outputs are registered and update on the clk edge where clk_enable=1; one-cycle latency from the qualifying input.
- depkt_rst is high on the first HOLDOFF cycle only and stays high across clk_enable-low cycles until the next enabled edge.
- Reset values: state IDLE, pd_enable=0, bd_enable=0, depkt_rst=0, busy=0, all counters 0, watchdog 0.
- rst_n asserted mid-frame clears everything immediately, with no depkt_rst pulse.
- Flags sampled while clk_enable=0 are ignored.

## Configuration
- RX_SESSION_STATS_EN:
  - Defined: pkt_count, drop_count and timeout_count are implemented as above.
  - Undefined: the counter registers are removed and the three ports are tied to 0. FSM, watchdog and depkt_rst behaviour is unchanged.

## Test plan
- Good frame: SD↑, PD↑ 5 cycles later, BD↑ 10 cycles later, 40 beats ending with tlast → states 1→2→3→4→0; pkt_count=1; one depkt_rst pulse; pd_enable/bd_enable high only in the specified states.
- SD drop in RECV after 12 beats → HOLDOFF next enabled cycle; drop_count=1; depkt_rst pulse; IDLE after 8 enabled cycles.
- Stall: TIMEOUT_CYCLES=16, data_tready held low in RECV → HOLDOFF exactly 16 enabled cycles after last progress; timeout_count=1.
- Header abort: disassert_PD pulse with no tlast in RECV → drop_count=1, pkt_count unchanged. Same-cycle tlast+SD drop → pkt_count+1, drop_count unchanged.
- clk_enable toggling 1-of-4 during a full frame → same transitions and counts as the first scenario, stretched 4×. rst_n low mid-RECV → all outputs 0 asynchronously.
- Saturation: CNT_WIDTH=2, 5 good frames → pkt_count=3. Macro undefined → counters read 0 throughout.
